pong_match_ctrl: RTL

//  Parametrised match/round sequencer for the pong datapath. Counts points and

---
 rtl/pong_match_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Match/round sequencer for pong: counts points, enforces a serve delay, decides the winner.
// Latency: outputs are decoded from registered state; a miss updates score/winner on its edge.
// Backpressure: start=0 freezes all state and forces ball_on/round_reset/point_pulse low.
// Optional feature macro: PONG_WIN_BY_TWO_EN (deuce play, win needs a 2-point lead).
module pong_match_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 10,
  parameter int DELAY_CYCLES = 81000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               new_game,
  input  logic               miss_valid,
  input  logic               miss_side,
  output logic               ball_on,
  output logic               round_reset,
  output logic               serve_dir,
  output logic               point_pulse,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner
);

  localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DELAY = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         winner_q, winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               point_pulse_q, point_pulse_d;

  // Candidate scores if this miss is awarded; they stick at the maximum instead of wrapping.
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic               p1_win, p2_win;

  assign p1_inc = (p1_q == SCORE_MAX) ? p1_q : p1_q + SCORE_W'(1);
  assign p2_inc = (p2_q == SCORE_MAX) ? p2_q : p2_q + SCORE_W'(1);

`ifdef PONG_WIN_BY_TWO_EN
  // Deuce play: need the target and a two-point lead; a saturated counter ends the match.
  assign p1_win = (p1_inc == SCORE_MAX) ||
                  ((p1_inc >= WIN_VAL) && ({1'b0, p1_inc} >= {1'b0, p2_q} + (SCORE_W+1)'(2)));
  assign p2_win = (p2_inc == SCORE_MAX) ||
                  ((p2_inc >= WIN_VAL) && ({1'b0, p2_inc} >= {1'b0, p1_q} + (SCORE_W+1)'(2)));
`else
  // First to the target wins; lead is irrelevant.
  assign p1_win = (p1_inc == WIN_VAL) || (p1_inc == SCORE_MAX);
  assign p2_win = (p2_inc == WIN_VAL) || (p2_inc == SCORE_MAX);
`endif

  // Next-state logic: new_game overrides everything, otherwise the FSM only advances while start=1.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    point_pulse_d = 1'b0;
    if (new_game) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      p1_d        = '0;
      p2_d        = '0;
      winner_d    = 2'd0;
      serve_dir_d = 1'b1;
    end else if (start) begin
      case (state_q)
        ST_IDLE:  state_d = ST_SERVE;
        ST_SERVE: state_d = ST_PLAY;
        ST_PLAY: begin
          if (miss_valid) begin
            // Next serve goes toward the player who just conceded.
            serve_dir_d   = miss_side;
            point_pulse_d = 1'b1;
            state_d       = ST_DELAY;
            if (miss_side) begin
              p1_d = p1_inc;
              if (p1_win) begin
                winner_d = 2'd1;
                state_d  = ST_OVER;
              end
            end else begin
              p2_d = p2_inc;
              if (p2_win) begin
                winner_d = 2'd2;
                state_d  = ST_OVER;
              end
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OVER:  state_d = ST_OVER;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers with asynchronous full clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      winner_q      <= 2'd0;
      serve_dir_q   <= 1'b1;
      point_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      winner_q      <= winner_d;
      serve_dir_q   <= serve_dir_d;
      point_pulse_q <= point_pulse_d;
    end
  end

  // Pausing blanks the ball and suppresses the pulses without disturbing stored state.
  assign ball_on     = start & (state_q == ST_PLAY);
  assign round_reset = start & (state_q == ST_SERVE);
  assign point_pulse = start & point_pulse_q;
  assign serve_dir   = serve_dir_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign winner      = winner_q;

endmodule
